// File: rtl/im_fetch_unit.sv
// Instruction fetch unit: drives the im read port and buffers {pc, instr} pairs
// in a small circular queue for decode, with redirect, end-of-memory halt and fault.
module im_fetch_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int MEM_BYTES   = 56,
  parameter int RESET_PC    = 0,
  parameter int QDEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    updatedPC,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   dec_ready,
  output logic                   dec_valid,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [PC_WIDTH-1:0]    dec_pc,
  output logic                   halted,
  output logic                   fault
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PC_WIDTH-1:0] MEM_END = PC_WIDTH'(MEM_BYTES);
  localparam logic [CW-1:0]       FULL    = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} state_t;
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  state_t        state;
  entry_t        q [QDEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          pop, push, at_end;

  assign dec_valid = (cnt != '0);
  assign dec_instr = q[rptr].instr;
  assign dec_pc    = q[rptr].pc;
  assign at_end    = (updatedPC >= MEM_END);
  assign pop       = dec_valid && dec_ready;
  // a pop frees the slot the same cycle, so a full queue still streams
  assign push      = (state == FETCH) && !redirect && !at_end && ((cnt != FULL) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      updatedPC <= PC_WIDTH'(RESET_PC);
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (state == FAULT) begin
      cnt  <= '0;
      rptr <= wptr;
    end else if (redirect) begin
      cnt  <= '0;
      rptr <= wptr;
      if (redirect_pc[0]) begin
        // misaligned target: freeze the PC so updatedPC[0] stays clear
        state  <= FAULT;
        fault  <= 1'b1;
        halted <= 1'b1;
      end else begin
        state     <= FETCH;
        updatedPC <= redirect_pc;
        halted    <= 1'b0;
      end
    end else begin
      if (state == IDLE) state <= FETCH;
      if (state == FETCH && at_end) begin
        state  <= HALT;
        halted <= 1'b1;
      end
      if (push) begin
        q[wptr]   <= '{pc: updatedPC, instr: instruction};
        wptr      <= wptr + PW'(1);
        updatedPC <= updatedPC + PC_WIDTH'(2);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_im_fetch_unit.sv
// Bench for im_fetch_unit: directed scenarios pinned with literals plus a
// randomized run, all compared each cycle against a queue-based reference model.
module tb_im_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] updatedPC, instruction, redirect_pc, dec_instr, dec_pc;
  logic        redirect = 1'b0, dec_ready = 1'b0;
  logic        dec_valid, halted, fault;

  im_fetch_unit dut (
    .clk(clk), .reset(reset), .updatedPC(updatedPC), .instruction(instruction),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];

  function automatic logic [15:0] rd(input logic [15:0] pc);
    if (pc < 16'd63) return {mem[pc[5:0]], mem[pc[5:0] + 6'd1]};
    return 16'h0;
  endfunction

  assign instruction = rd(updatedPC);

  // reference model: architectural view of the fetch unit
  typedef struct {logic [15:0] pc; logic [15:0] ins;} ent_t;
  ent_t        mq[$];
  logic [15:0] mpc;
  bit          mstarted, mhalt, mfault;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mpc = 16'h0; mstarted = 0; mhalt = 0; mfault = 0;
  endtask

  task automatic model_next(input logic r, input logic [15:0] rpc, input logic rdy);
    bit pop = (mq.size() > 0) && rdy;
    if (mfault) mq.delete();
    else if (r) begin
      mq.delete();
      if (rpc[0]) begin mfault = 1; mhalt = 1; end
      else begin mpc = rpc; mhalt = 0; mstarted = 1; end
    end else begin
      if (pop) void'(mq.pop_front());
      if (!mstarted) mstarted = 1;
      else if (!mhalt) begin
        if (mpc >= 16'd56) mhalt = 1;
        else if (mq.size() < 2) begin
          mq.push_back('{pc: mpc, ins: rd(mpc)});
          mpc = mpc + 16'd2;
        end
      end
    end
  endtask

  task automatic compare();
    chk("updatedPC", updatedPC, mpc);
    chk("halted", halted, mhalt);
    chk("fault", fault, mfault);
    chk("dec_valid", dec_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("dec_pc", dec_pc, mq[0].pc);
      chk("dec_instr", dec_instr, mq[0].ins);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] rpc, input logic rdy);
    redirect = r; redirect_pc = rpc; dec_ready = rdy;
    model_next(r, rpc, rdy);
    @(posedge clk); @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    redirect = 0; redirect_pc = 0; dec_ready = 0;
    @(negedge clk); reset = 0;
    @(negedge clk);
    model_reset();
    compare();
    reset = 1;
  endtask

  logic [15:0] frozen;
  int          n;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'h78; mem[4] = 8'h9a; mem[5] = 8'hbc;
    redirect_pc = 16'h0;
    model_reset();

    // 1 streaming
    do_reset();
    chk("rst_valid", dec_valid, 0); chk("rst_pc", dec_pc, 0); chk("rst_instr", dec_instr, 0);
    step(0, 0, 1);
    chk("bubble_valid", dec_valid, 0);
    step(0, 0, 1);
    chk("s1_pc", dec_pc, 16'h0000); chk("s1_instr", dec_instr, 16'h1234);
    step(0, 0, 1);
    chk("s2_pc", dec_pc, 16'h0002); chk("s2_instr", dec_instr, 16'h5678);
    step(0, 0, 1);
    chk("s3_pc", dec_pc, 16'h0004); chk("s3_instr", dec_instr, 16'h9abc);

    // 2 backpressure
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("bp_upc", updatedPC, 16'h0004); chk("bp_pc", dec_pc, 16'h0000);
    chk("bp_valid", dec_valid, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // 3 redirect while full
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(1, 16'h0010, 0);
    chk("rd_valid", dec_valid, 0); chk("rd_upc", updatedPC, 16'h0010);
    step(0, 0, 0);
    chk("rd_pc", dec_pc, 16'h0010); chk("rd_valid2", dec_valid, 1);

    // 4 end of memory
    step(1, 16'h0030, 1);
    n = 0;
    while (updatedPC != 16'h0038 && n < 40) begin step(0, 0, 1); n++; end
    chk("eom_reached", n < 40, 1);
    chk("eom_last_pc", dec_pc, 16'h0036);
    step(0, 0, 1);
    chk("eom_halted", halted, 1); chk("eom_drained", dec_valid, 0);
    step(0, 0, 1);
    step(1, 16'h0000, 1);
    chk("eom_unhalt", halted, 0); chk("eom_restart", updatedPC, 16'h0000);
    step(0, 0, 1);
    chk("eom_pc0", dec_pc, 16'h0000);

    // 5 misaligned redirect
    frozen = updatedPC;
    step(1, 16'h0011, 1);
    chk("mis_fault", fault, 1); chk("mis_halted", halted, 1);
    chk("mis_valid", dec_valid, 0); chk("mis_upc", updatedPC, frozen);
    step(1, 16'h0020, 1);
    chk("mis_ignore", updatedPC, frozen); chk("mis_sticky", fault, 1);

    // 6 mid-stream async reset
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    #2 reset = 0;
    #1;
    chk("ar_upc", updatedPC, 16'h0); chk("ar_valid", dec_valid, 0);
    chk("ar_pc", dec_pc, 16'h0); chk("ar_instr", dec_instr, 16'h0);
    chk("ar_halted", halted, 0); chk("ar_fault", fault, 0);
    model_reset();
    @(negedge clk); reset = 1;
    step(0, 0, 1); step(0, 0, 1);
    chk("ar_first_pc", dec_pc, 16'h0000); chk("ar_first_valid", dec_valid, 1);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [15:0] rpc;
      if (i % 300 == 299) do_reset();
      r   = ($urandom_range(0, 99) < 4);
      rpc = 16'($urandom_range(0, 31) * 2);
      if ($urandom_range(0, 9) == 0) rpc = rpc | 16'h1;
      step(r, rpc, $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
